// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC handshake sender and the future receive-side block.
package cdc_pkg;

  localparam logic [1:0] HS_IDLE   = 2'd0;
  localparam logic [1:0] HS_REQ_HI = 2'd1;
  localparam logic [1:0] HS_REQ_LO = 2'd2;

  localparam int unsigned CDC_DATA_WIDTH = 8;
  localparam int unsigned CDC_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    StIdle  = HS_IDLE,
    StReqHi = HS_REQ_HI,
    StReqLo = HS_REQ_LO
  } hs_state_e;

endpackage

// File: rtl/cdc_hs_tx_if.sv
// Producer valid/ready side plus req/ack/data toward the synchronizer.
// master is the sender's view; slave is the producer/synchronizer view.
interface cdc_hs_tx_if
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CDC_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] hs_data;
  logic                  hs_req;
  logic                  hs_ack;

  modport master (
    input  s_data,
    input  s_valid,
    input  hs_ack,
    output s_ready,
    output hs_data,
    output hs_req
  );

  modport slave (
    output s_data,
    output s_valid,
    output hs_ack,
    input  s_ready,
    input  hs_data,
    input  hs_req
  );
endinterface

// File: rtl/cdc_hs_timer.sv
// Ack-wait watchdog: restartable saturating counter with a sticky error flag.
module cdc_hs_timer
  import cdc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_err
);
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] r_cnt;
  logic                r_err;
  logic                w_fire;

  // Counter parks one above the trip value so the flag fires once per wait phase.
  assign w_fire = i_inc && (r_cnt == CntWidth'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_load) begin
        r_cnt <= '0;
      end else if (i_inc && (r_cnt != CntWidth'(TIMEOUT_CYCLES))) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fire) begin
        r_err <= 1'b1;
      end else if (i_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_err = r_err;
endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side 4-phase req/ack sender with a one-entry pending register.
// Optional ack watchdog enabled by CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = CDC_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH      = CDC_CNT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cdc_hs_tx_if.master          bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] xfer_cnt,
  input  logic                 err_clr,
  output logic                 timeout_err
);
  hs_state_e             r_state, w_state_d;
  logic                  r_pend_valid, w_pend_valid_d;
  logic [DATA_WIDTH-1:0] r_pend, w_pend_d;
  logic [DATA_WIDTH-1:0] r_hs_data, w_hs_data_d;
  logic                  r_hs_req, w_hs_req_d;
  logic [CNT_WIDTH-1:0]  r_xfer_cnt, w_xfer_cnt_d;
  logic                  w_s_ready;
  logic                  w_accept;
  logic                  w_wait_load;
  logic                  w_wait_inc;

  assign w_s_ready = !r_pend_valid || (r_state == StIdle);
  assign w_accept  = bus.s_valid && w_s_ready;

  always_comb begin
    w_state_d      = r_state;
    w_pend_valid_d = r_pend_valid;
    w_pend_d       = r_pend;
    w_hs_data_d    = r_hs_data;
    w_hs_req_d     = r_hs_req;
    w_xfer_cnt_d   = r_xfer_cnt;
    w_wait_load    = 1'b0;
    w_wait_inc     = 1'b0;

    unique case (r_state)
      StIdle: begin
        // A stale ack from the previous transfer must clear before a new req.
        if (r_pend_valid && !bus.hs_ack) begin
          w_hs_data_d    = r_pend;
          w_hs_req_d     = 1'b1;
          w_pend_valid_d = 1'b0;
          w_wait_load    = 1'b1;
          w_state_d      = StReqHi;
        end
      end
      StReqHi: begin
        if (bus.hs_ack) begin
          w_hs_req_d   = 1'b0;
          w_xfer_cnt_d = r_xfer_cnt + 1'b1;
          w_wait_load  = 1'b1;
          w_state_d    = StReqLo;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      StReqLo: begin
        if (!bus.hs_ack) begin
          w_state_d = StIdle;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Accept overrides the drain so a same-edge refill keeps the entry valid.
    if (w_accept) begin
      w_pend_d       = bus.s_data;
      w_pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_hs_data    <= '0;
      r_hs_req     <= 1'b0;
      r_xfer_cnt   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_pend_valid <= w_pend_valid_d;
      r_pend       <= w_pend_d;
      r_hs_data    <= w_hs_data_d;
      r_hs_req     <= w_hs_req_d;
      r_xfer_cnt   <= w_xfer_cnt_d;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.hs_data = r_hs_data;
  assign bus.hs_req  = r_hs_req;
  assign busy        = (r_state != StIdle) || r_pend_valid;
  assign xfer_cnt    = r_xfer_cnt;

`ifdef CDC_HS_TX_TIMEOUT_EN
  cdc_hs_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_wait_load),
    .i_inc (w_wait_inc),
    .i_clr (err_clr),
    .o_err (timeout_err)
  );
`else
  logic w_unused_timer;
  assign w_unused_timer = ^{err_clr, w_wait_load, w_wait_inc, TIMEOUT_CYCLES[0]};
  assign timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx: reset, single/back-to-back transfers, stale ack,
// ack timeout (either build), and reset mid-handshake.
module tb_cdc_hs_tx;
  import cdc_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          err_clr;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] xfer_cnt;

  logic ack_auto, ack_man, ack_mdl, mon_en;
  int   ack_dly;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  cdc_hs_tx_if #(.DATA_WIDTH(DW)) hs_if ();

  cdc_hs_tx #(
    .DATA_WIDTH    (DW),
    .CNT_WIDTH     (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (hs_if.master),
    .busy       (busy),
    .xfer_cnt   (xfer_cnt),
    .err_clr    (err_clr),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign hs_if.hs_ack = ack_auto ? ack_mdl : ack_man;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, output int waits);
    int n = 0;
    hs_if.s_data  = w;
    hs_if.s_valid = 1'b1;
    while (!hs_if.s_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("send_ready", hs_if.s_ready, 1);
    tick();
    hs_if.s_valid = 1'b0;
    waits = n;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  // Ack responder: mirrors req two sampled cycles after it changes.
  initial begin
    ack_mdl = 1'b0;
    ack_dly = 0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_auto && (hs_if.hs_req != ack_mdl)) begin
        ack_dly++;
        if (ack_dly == 2) begin
          ack_mdl = hs_if.hs_req;
          ack_dly = 0;
        end
      end else begin
        ack_dly = 0;
      end
    end
  end

  // Every raised req must carry the next expected word, held for the whole req-high window.
  initial begin
    logic          prev_req;
    logic [DW-1:0] cur_exp;
    prev_req = 1'b0;
    cur_exp  = '0;
    forever begin
      @(negedge clk);
      if (mon_en && hs_if.hs_req === 1'b1) begin
        if (prev_req !== 1'b1) begin
          check_eq("req_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
        end
        check_eq("hs_data_order_stable", hs_if.hs_data, cur_exp);
      end
      prev_req = hs_if.hs_req;
    end
  end

  initial begin
    int w;
    hs_if.s_data  = '0;
    hs_if.s_valid = 1'b0;
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    mon_en   = 1'b0;
    err_clr  = 1'b0;
    rst_n    = 1'b0;

    // Reset with a valid word offered
    hs_if.s_valid = 1'b1;
    hs_if.s_data  = 8'h5A;
    tick();
    tick();
    rst_n = 1'b1;
    hs_if.s_valid = 1'b0;
    check_eq("rst_hs_req", hs_if.hs_req, 0);
    check_eq("rst_hs_data", hs_if.hs_data, 0);
    check_eq("rst_xfer_cnt", xfer_cnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_s_ready", hs_if.s_ready, 1);
    check_eq("rst_timeout_err", timeout_err, 0);

    // Single word
    mon_en   = 1'b1;
    ack_auto = 1'b1;
    exp_q.push_back(8'hA5);
    hs_if.s_data  = 8'hA5;
    hs_if.s_valid = 1'b1;
    tick();
    hs_if.s_valid = 1'b0;
    check_eq("single_busy_pending", busy, 1);
    check_eq("single_req_not_yet", hs_if.hs_req, 0);
    tick();
    check_eq("single_req_up", hs_if.hs_req, 1);
    check_eq("single_data", hs_if.hs_data, 8'hA5);
    wait_idle("single");
    check_eq("single_xfer_cnt", xfer_cnt, 1);
    check_eq("single_req_down", hs_if.hs_req, 0);

    // Back-to-back
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send(8'h11, w);
    send(8'h22, w);
    check_eq("b2b_ready_full", hs_if.s_ready, 0);
    check_eq("b2b_req_first", hs_if.hs_req, 1);
    check_eq("b2b_data_first", hs_if.hs_data, 8'h11);
    check_eq("b2b_busy", busy, 1);
    send(8'h33, w);
    check_eq("b2b_third_stalled", w > 0, 1);
    wait_idle("b2b");
    check_eq("b2b_xfer_cnt", xfer_cnt, 4);
    check_eq("b2b_all_delivered", exp_q.size(), 0);

    // Stale ack in IDLE
    ack_auto = 1'b0;
    ack_man  = 1'b1;
    exp_q.push_back(8'h44);
    send(8'h44, w);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stale_req_held_low", hs_if.hs_req, 0);
    end
    check_eq("stale_busy", busy, 1);
    ack_man = 1'b0;
    tick();
    check_eq("stale_req_up", hs_if.hs_req, 1);
    check_eq("stale_data", hs_if.hs_data, 8'h44);
    ack_man = 1'b1;
    tick();
    check_eq("stale_req_down", hs_if.hs_req, 0);
    check_eq("stale_xfer_cnt", xfer_cnt, 5);
    ack_man = 1'b0;
    tick();
    check_eq("stale_idle", busy, 0);

    // Ack timeout
    exp_q.push_back(8'h55);
    send(8'h55, w);
    tick();
    check_eq("to_req_up", hs_if.hs_req, 1);
`ifdef CDC_HS_TX_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    check_eq("to_hi_before", timeout_err, 0);
    tick();
    check_eq("to_hi_set", timeout_err, 1);
    check_eq("to_hi_req_held", hs_if.hs_req, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("to_clr", timeout_err, 0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("to_clr_sticks", timeout_err, 0);
    check_eq("to_still_waiting", hs_if.hs_req, 1);
    ack_man = 1'b1;
    tick();
    check_eq("to_xfer_cnt", xfer_cnt, 6);
    for (int i = 0; i < 7; i++) tick();
    check_eq("to_lo_before", timeout_err, 0);
    tick();
    check_eq("to_lo_set", timeout_err, 1);
    ack_man = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("to_final_clr", timeout_err, 0);
`else
    for (int i = 0; i < 12; i++) begin
      err_clr = (i % 3 == 0);
      tick();
    end
    err_clr = 1'b0;
    check_eq("to_off_flag", timeout_err, 0);
    check_eq("to_off_req_held", hs_if.hs_req, 1);
    ack_man = 1'b1;
    tick();
    check_eq("to_xfer_cnt", xfer_cnt, 6);
    ack_man = 1'b0;
    tick();
    check_eq("to_off_flag_end", timeout_err, 0);
`endif
    check_eq("to_idle", busy, 0);

    // Reset mid-handshake (REQ_LO with a word pending)
    exp_q.push_back(8'h66);
    send(8'h66, w);
    tick();
    ack_man = 1'b1;
    tick();
    check_eq("rmid_xfer_cnt", xfer_cnt, 7);
    send(8'h67, w);
    check_eq("rmid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check_eq("rmid_hs_req", hs_if.hs_req, 0);
    check_eq("rmid_hs_data", hs_if.hs_data, 0);
    check_eq("rmid_xfer_cnt_clr", xfer_cnt, 0);
    check_eq("rmid_busy_clr", busy, 0);
    check_eq("rmid_s_ready", hs_if.s_ready, 1);
    check_eq("rmid_timeout_err", timeout_err, 0);
    rst_n    = 1'b1;
    ack_man  = 1'b0;
    ack_auto = 1'b1;
    exp_q.push_back(8'h77);
    send(8'h77, w);
    wait_idle("rmid_after");
    check_eq("rmid_after_xfer_cnt", xfer_cnt, 1);
    check_eq("rmid_all_delivered", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Source-side 4-phase request/acknowledge sender. It sits directly upstream of `cdc_sync_handshake` in the sending clock domain. It accepts words from local logic on a valid/ready interface and presents each word as a stable `hs_data` with `hs_req`. It then completes the full req↑ → ack↑ → req↓ → ack↓ sequence against the synchronized acknowledge before launching the next word. A one-entry pending register lets the producer hand over the next word while the current handshake is still in flight.

## Interface
- `DATA_WIDTH`, 8, width of the transferred word
- `CNT_WIDTH`, 16, width of the completed-transfer counter
- `TIMEOUT_CYCLES`, 1024, ack wait limit in `clk` cycles (used only with the timeout feature)

Ports:
- `clk` in 1: sending-domain clock (same clock as `clk_src` of the synchronizer)
- `rst_n` in 1: reset, synchronous, active-low
- `s_data` in DATA_WIDTH: word from the producer
- `s_valid` in 1: producer word valid
- `s_ready` out 1: block can accept `s_data`
- `hs_data` out DATA_WIDTH: registered word, drives the synchronizer's `in_data`
- `hs_req` out 1: registered request, drives `in_req`
- `hs_ack` in 1: acknowledge already synchronized into `clk`; driven from `in_ack`
- `busy` out 1: a word is pending or a handshake is in progress
- `xfer_cnt` out CNT_WIDTH: number of completed transfers, wraps modulo 2^CNT_WIDTH
- `err_clr` in 1: clears `timeout_err`
- `timeout_err` out 1: sticky ack-timeout flag

## Operation
- **Reset values** (at the first `clk` edge with `rst_n`=0): state IDLE, `pend_valid`=0, `hs_req`=0, `hs_data`=0, `xfer_cnt`=0, `timeout_err`=0, timeout counter 0.
- **Accept rule:** `s_ready` = !`pend_valid` | (state==IDLE). A word is taken into the pending register at an edge where `s_valid`&`s_ready`=1.
- **State machine:**
  - IDLE: if `pend_valid`, load `hs_data`<=pend, set `hs_req`<=1, clear `pend_valid` (unless a new word is accepted at the same edge), go to REQ_HI.
  - REQ_HI: wait for `hs_ack`=1. On that edge set `hs_req`<=0, increment `xfer_cnt`, go to REQ_LO.
  - REQ_LO: wait for `hs_ack`=0, then go to IDLE.
- **Data stability:** `hs_data` changes only on the IDLE→REQ_HI transition. It is stable from the raising of `hs_req` until the return to IDLE.
- **Ack in IDLE:** `hs_ack`=1 in IDLE is ignored, and no req is raised until ack is 0. IDLE→REQ_HI requires `hs_ack`=0. Otherwise wait in IDLE.
- **`busy`** = (state!=IDLE) | `pend_valid`.
- **Simultaneous drain and accept in IDLE:** both occur at the same edge. The old pending word goes to `hs_data`, the new word goes to the pending register, and `pend_valid` stays 1.
- **Producer stall:** if `s_valid` is held with `s_ready`=0, `s_data` need not be sampled, and nothing is lost.
- **Reset mid-handshake:** `hs_req` drops at the reset edge. The receiving domain is reset by the same system reset. No recovery of the in-flight word.

## Timing
- Word accepted at edge k with state IDLE and `pend_valid`=0: `hs_req`=1 and `hs_data` valid after edge k+1.
- `hs_ack` rises and is sampled at edge a: `hs_req`=0 and `xfer_cnt` updated after edge a.
- `hs_ack` falls and is sampled at edge b: state is IDLE after edge b. A pending word raises `hs_req` after edge b+1.
- Minimum spacing between `hs_req` rising edges: 3 cycles plus the ack round-trip.
- All outputs are registered except `s_ready` and `busy`, which are decoded from flops only. There is no combinational path from `s_valid` to any output.

## Configuration
- Feature macro: `CDC_HS_TX_TIMEOUT_EN`.
- **Defined:**
  - A counter restarts on entry to REQ_HI or REQ_LO and increments each cycle while the awaited ack level is absent.
  - When the counter reaches `TIMEOUT_CYCLES`-1, `timeout_err`<=1 (sticky) and the counter saturates.
  - The FSM keeps waiting and never aborts.
  - `err_clr`=1 clears the flag at the next edge. If clear and set occur at the same edge, set wins.
- **Undefined:** no counter logic. `timeout_err` is tied 0 and `err_clr` is ignored.

## Structure
- Shared package `cdc_pkg`:
  - state encoding localparams `HS_IDLE`=2'd0, `HS_REQ_HI`=2'd1, `HS_REQ_LO`=2'd2
  - default `DATA_WIDTH`/`CNT_WIDTH` constants, shared with the future receive-side block
- Sub-module: `cdc_hs_timer` (load/increment/saturate counter plus sticky flag), instantiated only under `CDC_HS_TX_TIMEOUT_EN`. The FSM and pending register stay in the top.

## Test plan
- **Reset:** `rst_n`=0 for 2 edges with `s_valid`=1 → `hs_req`=0, `hs_data`=0, `xfer_cnt`=0, `busy`=0, `s_ready`=1 after release.
- **Single word:** word 8'hA5 accepted at edge 0, ack model returns ack 2 cycles after req↑ and drops 2 cycles after req↓ → `hs_req`↑ after edge 1 with `hs_data`=8'hA5, `xfer_cnt`=1, back in IDLE, `busy`=0.
- **Back-to-back:** 8'h11, 8'h22, 8'h33 with `s_valid` held → 8'h22 accepted during the first handshake, `s_ready`=0 while pending is full and not IDLE, words delivered in order, `xfer_cnt`=3, `hs_data` never changes while `hs_req`=1.
- **Stale ack:** `hs_ack` forced 1 in IDLE with a word pending → `hs_req` stays 0 until ack drops, then rises 1 cycle later.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8):** ack never returns → `timeout_err`=1 after 8 cycles in REQ_HI, `hs_req` stays 1. Pulse `err_clr` → flag 0 until the next timeout. Macro off → `timeout_err` constant 0.
- **Reset mid-handshake:** `rst_n`=0 while in REQ_LO → all outputs return to reset values at that edge, and the next word after release completes normally.
